// File: rtl/msrv32_fetch_pkg.sv
// -----------------------------------------------------------------------------
// msrv32_fetch_pkg
// Shared constants and types for the instruction-fetch front end.
//   XLEN         : datapath width
//   NOP_INSTR    : instruction shown to decode when nothing valid is available
//   PC_INC       : sequential PC step
//   fetch_entry_t: one prefetch FIFO slot {instr, pc}
// -----------------------------------------------------------------------------
package msrv32_fetch_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INC    = 32'h0000_0004;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/msrv32_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// msrv32_fetch_unit_if
// Instruction-memory request/response bus.
//   imem_req_out   : fetch request (fetch -> memory)
//   imem_addr_out  : word-aligned fetch address (fetch -> memory)
//   imem_gnt_in    : request accepted this cycle (memory -> fetch)
//   imem_rvalid_in : read data valid (memory -> fetch)
//   imem_rdata_in  : read data (memory -> fetch)
// Modports: master = fetch unit, slave = instruction memory.
// -----------------------------------------------------------------------------
interface msrv32_fetch_unit_if;

  logic                               imem_req_out;
  logic [msrv32_fetch_pkg::XLEN-1:0]  imem_addr_out;
  logic                               imem_gnt_in;
  logic                               imem_rvalid_in;
  logic [msrv32_fetch_pkg::XLEN-1:0]  imem_rdata_in;

  modport master (
    output imem_req_out,
    output imem_addr_out,
    input  imem_gnt_in,
    input  imem_rvalid_in,
    input  imem_rdata_in
  );

  modport slave (
    input  imem_req_out,
    input  imem_addr_out,
    output imem_gnt_in,
    output imem_rvalid_in,
    output imem_rdata_in
  );

endinterface

// File: rtl/msrv32_fetch_fifo.sv
// -----------------------------------------------------------------------------
// msrv32_fetch_fifo
// Prefetch FIFO holding fetched words with their PCs. The head is read
// straight from the storage registers, so a word pushed in one cycle is
// visible at the head the next cycle.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_push/i_data: write an entry (ignored when full)
//   i_pop        : retire the head entry (ignored when empty)
//   i_flush      : discard everything, including a push in the same cycle
//   o_count      : number of stored entries
//   o_full       : count == DEPTH
//   o_head       : oldest entry (meaningless when o_count == 0)
// -----------------------------------------------------------------------------
module msrv32_fetch_fifo
  import msrv32_fetch_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  fetch_entry_t  i_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output fetch_entry_t  o_head
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = i_push && (r_count != CNT_FULL);
  assign w_pop  = i_pop  && (r_count != CNT_ZERO);

  // Pointer and occupancy bookkeeping; flush empties the FIFO outright.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= CNT_ZERO;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are only observed while o_count > 0.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush && !i_rst) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_count = r_count;
  assign o_full  = (r_count == CNT_FULL);
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/msrv32_fetch_unit.sv
// -----------------------------------------------------------------------------
// msrv32_fetch_unit
// Instruction-fetch front end: owns the fetch PC, issues one request at a
// time to instruction memory, buffers returned words in a prefetch FIFO and
// presents the FIFO head to decode. A taken branch redirects the PC, empties
// the FIFO and marks any in-flight response to be dropped.
//   ms_riscv32_mp_clk_in / _rst_in : clock, synchronous active-high reset
//   imem                           : instruction memory bus (master side)
//   branch_taken_in/_target_in     : redirect request and target PC
//   stall_in                       : decode is not consuming
//   ms_riscv32_mp_instr_out        : instruction to decode (NOP when empty)
//   instr_pc_out                   : PC of that instruction (last PC when empty)
//   instr_valid_out                : FIFO head valid
//   flush_out                      : decode must emit a NOP
// -----------------------------------------------------------------------------
module msrv32_fetch_unit
  import msrv32_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic                       ms_riscv32_mp_clk_in,
  input  logic                       ms_riscv32_mp_rst_in,
  msrv32_fetch_unit_if.master        imem,
  input  logic                       branch_taken_in,
  input  logic [XLEN-1:0]            branch_target_in,
  input  logic                       stall_in,
  output logic [XLEN-1:0]            ms_riscv32_mp_instr_out,
  output logic [XLEN-1:0]            instr_pc_out,
  output logic                       instr_valid_out,
  output logic                       flush_out
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_pc;
  logic [XLEN-1:0] r_last_pc;
  logic            r_outstanding;
  logic            r_drop;

  logic            w_req;
  logic            w_hs;
  logic            w_resp;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic [CW-1:0]   w_count;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_data;

  // The free-slot test counts the outstanding request implicitly: a new
  // request only issues once the previous response has come back.
  assign w_req  = !ms_riscv32_mp_rst_in && !r_outstanding && !w_full && !branch_taken_in;
  assign w_hs   = w_req && imem.imem_gnt_in;
  assign w_resp = imem.imem_rvalid_in && r_outstanding;
  assign w_push = w_resp && !r_drop && !branch_taken_in;
  assign w_pop  = instr_valid_out && !stall_in;

  assign w_push_data.instr = imem.imem_rdata_in;
  assign w_push_data.pc    = r_req_pc;

  assign imem.imem_req_out  = w_req;
  assign imem.imem_addr_out = r_pc;

  msrv32_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (ms_riscv32_mp_clk_in),
    .i_rst   (ms_riscv32_mp_rst_in),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_flush (branch_taken_in),
    .o_count (w_count),
    .o_full  (w_full),
    .o_head  (w_head)
  );

  // PC, outstanding-request and drop-flag control.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_pc          <= RESET_PC;
      r_req_pc      <= RESET_PC;
      r_outstanding <= 1'b0;
      r_drop        <= 1'b0;
    end else if (branch_taken_in) begin
      r_pc          <= align_word(branch_target_in);
      // Only a response still in flight after this cycle needs dropping.
      r_drop        <= (r_outstanding && !imem.imem_rvalid_in) || w_hs;
      if (w_hs)        r_outstanding <= 1'b1;
      else if (w_resp) r_outstanding <= 1'b0;
    end else begin
      if (w_hs) begin
        r_pc          <= r_pc + PC_INC;
        r_req_pc      <= r_pc;
        r_outstanding <= 1'b1;
      end else if (w_resp) begin
        r_outstanding <= 1'b0;
      end
      if (w_resp) r_drop <= 1'b0;
    end
  end

  // Remember the PC of the most recent head so an empty FIFO still reports it.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in)  r_last_pc <= RESET_PC;
    else if (instr_valid_out)  r_last_pc <= w_head.pc;
  end

  assign instr_valid_out         = (w_count != {CW{1'b0}});
  assign ms_riscv32_mp_instr_out = instr_valid_out ? w_head.instr : NOP_INSTR;
  assign instr_pc_out            = instr_valid_out ? w_head.pc    : r_last_pc;
  assign flush_out               = !instr_valid_out || branch_taken_in;

endmodule
